encap_sequencer: RTL and testbench

- Top-level control sequencer for Classic McEliece encapsulation.
- Buffers the 512-bit session seed delivered as 16 x 32-bit words.
- Launches three sub-units in order via start/done handshakes: FixedWeight error generation, encryption (C0 = H·e), and hash (K/C1).
- Arbitrates the single shared SHAKE (keccak) core between the error generator and the hash unit; raises phase flags and a final done.

---
 rtl/encap_sequencer.sv | 165 ++++++++++++++++
 tb/tb_encap_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encap_sequencer.sv
// Top-level control sequencer for Classic McEliece encapsulation: buffers the session
// seed, runs error generation, encryption and hashing in order, and shares one SHAKE core.
module encap_sequencer #(
  parameter int parameter_set = 1,
  parameter int n             = 3488,
  parameter int m             = 12,
  parameter int t             = 64,
  parameter int col_width     = 64,
  parameter int SEED_WORDS    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid,
  input  logic [31:0] seed,
  input  logic [3:0]  seed_rd_addr,
  output logic [31:0] seed_rd_data,
  output logic        err_start,
  output logic        enc_start,
  output logic        hash_start,
  input  logic        err_done,
  input  logic        enc_done,
  input  logic        hash_done,
  input  logic        err_din_valid,
  input  logic [31:0] err_din,
  input  logic        err_dout_ready,
  output logic        err_din_ready,
  output logic        err_dout_valid,
  output logic [31:0] err_dout,
  input  logic        hash_din_valid,
  input  logic [31:0] hash_din,
  input  logic        hash_dout_ready,
  output logic        hash_din_ready,
  output logic        hash_dout_valid,
  output logic [31:0] hash_dout,
  output logic        din_valid_shake_enc,
  output logic [31:0] din_shake_enc,
  output logic        dout_ready_shake_enc,
  input  logic        din_ready_shake,
  input  logic        dout_valid_shake,
  input  logic [31:0] dout_shake,
  output logic        force_done_shake,
  output logic        done_error,
  output logic        done_encrypt,
  output logic        done
);

  localparam int exp_n = (parameter_set == 1) ? 3488 : (parameter_set == 2) ? 4608 :
                         (parameter_set == 3) ? 6688 : (parameter_set == 4) ? 6960 : 8192;
  localparam int exp_m = (parameter_set == 1) ? 12 : 13;
  localparam int exp_t = (parameter_set == 1) ? 64 : (parameter_set == 2) ? 96 :
                         (parameter_set == 3) ? 128 : (parameter_set == 4) ? 119 : 128;

  // The code parameters only matter to the sub-units; catch an inconsistent set at elaboration.
  generate
    if (parameter_set < 1 || parameter_set > 5 || n != exp_n || m != exp_m || t != exp_t ||
        col_width < 32 || (col_width % 32) != 0 || SEED_WORDS != 16) begin : g_bad_params
      $error("encap_sequencer: inconsistent parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FW,
    ST_ENC,
    ST_HASH,
    ST_DONE
  } state_t;

  state_t      state, state_next;
  logic        first;
  logic [3:0]  cnt;
  logic [31:0] seed_buf [SEED_WORDS];
  logic        load_we;
  logic [3:0]  wr_addr;
  logic        fw_exit, hash_exit;

  assign load_we   = seed_valid && (state == ST_IDLE || state == ST_DONE);
  assign wr_addr   = (state == ST_DONE) ? 4'd0 : cnt;
  assign fw_exit   = (state == ST_FW)   && (state_next == ST_ENC);
  assign hash_exit = (state == ST_HASH) && (state_next == ST_DONE);

  // A done input coinciding with its own start pulse is stale and must not advance the phase.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (seed_valid && cnt == 4'(SEED_WORDS - 1)) state_next = ST_FW;
      ST_FW:   if (err_done && !first)  state_next = ST_ENC;
      ST_ENC:  if (enc_done && !first)  state_next = ST_HASH;
      ST_HASH: if (hash_done && !first) state_next = ST_DONE;
      ST_DONE: if (seed_valid)          state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      first            <= 1'b0;
      cnt              <= 4'd0;
      force_done_shake <= 1'b0;
      done_error       <= 1'b0;
      done_encrypt     <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_next;
      first            <= (state_next != state);
      force_done_shake <= fw_exit || hash_exit;
      if (state == ST_IDLE && seed_valid) cnt <= cnt + 4'd1;
      else if (state == ST_DONE && seed_valid) cnt <= 4'd1;
      if (state == ST_DONE && seed_valid) begin
        done_error   <= 1'b0;
        done_encrypt <= 1'b0;
        done         <= 1'b0;
      end else begin
        if (fw_exit) done_error <= 1'b1;
        if (state == ST_ENC && state_next == ST_HASH) done_encrypt <= 1'b1;
        if (hash_exit) done <= 1'b1;
      end
    end
  end

  // NOTE: the seed buffer has no reset; its contents are always rewritten before being read.
  always_ff @(posedge clk) begin
    if (load_we) seed_buf[wr_addr] <= seed;
  end

  assign seed_rd_data = seed_buf[seed_rd_addr];
  assign err_start    = (state == ST_FW)   && first;
  assign enc_start    = (state == ST_ENC)  && first;
  assign hash_start   = (state == ST_HASH) && first;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    din_valid_shake_enc  = 1'b0;
    din_shake_enc        = 32'd0;
    dout_ready_shake_enc = 1'b0;
    err_din_ready        = 1'b0;
    err_dout_valid       = 1'b0;
    err_dout             = 32'd0;
    hash_din_ready       = 1'b0;
    hash_dout_valid      = 1'b0;
    hash_dout            = 32'd0;
    case (state)
      ST_FW: begin
        din_valid_shake_enc  = err_din_valid;
        din_shake_enc        = err_din;
        dout_ready_shake_enc = err_dout_ready;
        err_din_ready        = din_ready_shake;
        err_dout_valid       = dout_valid_shake;
        err_dout             = dout_shake;
      end
      ST_HASH: begin
        din_valid_shake_enc  = hash_din_valid;
        din_shake_enc        = hash_din;
        dout_ready_shake_enc = hash_dout_ready;
        hash_din_ready       = din_ready_shake;
        hash_dout_valid      = dout_valid_shake;
        hash_dout            = dout_shake;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_encap_sequencer.sv
// Self-checking bench for encap_sequencer: seed words are scoreboarded on load and popped
// on buffer readback; phase pulses, flags and SHAKE muxing are checked cycle by cycle.
module tb_encap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_valid;
  logic [31:0] seed;
  logic [3:0]  seed_rd_addr;
  logic [31:0] seed_rd_data;
  logic        err_start, enc_start, hash_start;
  logic        err_done, enc_done, hash_done;
  logic        err_din_valid, err_dout_ready, err_din_ready, err_dout_valid;
  logic [31:0] err_din, err_dout;
  logic        hash_din_valid, hash_dout_ready, hash_din_ready, hash_dout_valid;
  logic [31:0] hash_din, hash_dout;
  logic        din_valid_shake_enc, dout_ready_shake_enc;
  logic [31:0] din_shake_enc;
  logic        din_ready_shake, dout_valid_shake;
  logic [31:0] dout_shake;
  logic        force_done_shake, done_error, done_encrypt, done;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  encap_sequencer dut (
    .clk(clk), .rst(rst),
    .seed_valid(seed_valid), .seed(seed),
    .seed_rd_addr(seed_rd_addr), .seed_rd_data(seed_rd_data),
    .err_start(err_start), .enc_start(enc_start), .hash_start(hash_start),
    .err_done(err_done), .enc_done(enc_done), .hash_done(hash_done),
    .err_din_valid(err_din_valid), .err_din(err_din), .err_dout_ready(err_dout_ready),
    .err_din_ready(err_din_ready), .err_dout_valid(err_dout_valid), .err_dout(err_dout),
    .hash_din_valid(hash_din_valid), .hash_din(hash_din), .hash_dout_ready(hash_dout_ready),
    .hash_din_ready(hash_din_ready), .hash_dout_valid(hash_dout_valid), .hash_dout(hash_dout),
    .din_valid_shake_enc(din_valid_shake_enc), .din_shake_enc(din_shake_enc),
    .dout_ready_shake_enc(dout_ready_shake_enc),
    .din_ready_shake(din_ready_shake), .dout_valid_shake(dout_valid_shake),
    .dout_shake(dout_shake),
    .force_done_shake(force_done_shake),
    .done_error(done_error), .done_encrypt(done_encrypt), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive count words base+i; optionally stall for 3 cycles before word 8.
  task automatic load_words(input logic [31:0] base, input int count, input bit pause);
    for (int i = 0; i < count; i++) begin
      step();
      if (pause && i == 8) begin
        seed_valid = 1'b0;
        repeat (3) begin
          check("no_start_in_pause", {31'd0, err_start}, 32'd0);
          step();
        end
      end
      if (i == 1) check("flags_clear", {29'd0, done, done_error, done_encrypt}, 32'd0);
      check("no_start_in_load", {31'd0, err_start}, 32'd0);
      seed_valid = 1'b1;
      seed       = base + 32'(i);
      sb_q.push_back(base + 32'(i));
    end
  endtask

  // The cycle after the final word is accepted must carry the single err_start pulse.
  task automatic finish_load();
    step();
    seed_valid = 1'b0;
    check("err_start_pulse", {31'd0, err_start}, 32'd1);
    step();
    check("err_start_once", {31'd0, err_start}, 32'd0);
  endtask

  task automatic readback();
    logic [31:0] exp;
    for (int a = 0; a < 16; a++) begin
      seed_rd_addr = 4'(a);
      #1;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        check($sformatf("seed_rd[%0d]", a), seed_rd_data, exp);
      end
    end
  endtask

  task automatic set_shake_inputs();
    dout_shake       = 32'hDEADBEEF;
    dout_valid_shake = 1'b1;
    din_ready_shake  = 1'b1;
    err_din_valid    = 1'b1;
    err_din          = 32'h12345678;
    err_dout_ready   = 1'b1;
    hash_din_valid   = 1'b1;
    hash_din         = 32'hCAFEF00D;
    hash_dout_ready  = 1'b1;
  endtask

  task automatic check_deselected(input string tag);
    check({tag, "_keccak"}, {din_valid_shake_enc, dout_ready_shake_enc, 30'd0} | din_shake_enc, 32'd0);
    check({tag, "_sides"}, {err_din_ready, err_dout_valid, hash_din_ready, hash_dout_valid, 28'd0}
                           | err_dout | hash_dout, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    seed_valid = 1'b0; seed = 32'd0; seed_rd_addr = 4'd0;
    err_done = 1'b0; enc_done = 1'b0; hash_done = 1'b0;
    err_din_valid = 1'b0; err_din = 32'd0; err_dout_ready = 1'b0;
    hash_din_valid = 1'b0; hash_din = 32'd0; hash_dout_ready = 1'b0;
    din_ready_shake = 1'b0; dout_valid_shake = 1'b0; dout_shake = 32'd0;
    repeat (2) step();
    check("rst_starts", {29'd0, err_start, enc_start, hash_start}, 32'd0);
    check("rst_flags", {28'd0, done, done_error, done_encrypt, force_done_shake}, 32'd0);
    rst = 1'b1;

    // Consecutive load of 0..15.
    load_words(32'd0, 16, 1'b0);
    finish_load();
    readback();

    // Extra seed_valid in FW must not touch the buffer.
    seed_valid = 1'b1; seed = 32'hBAD0BAD0;
    step();
    seed_valid = 1'b0;
    seed_rd_addr = 4'd0; #1;
    check("fw_seed_ignored", seed_rd_data, 32'd0);

    // SHAKE link routed to the error generator.
    set_shake_inputs();
    #1;
    check("fw_err_dout", err_dout, 32'hDEADBEEF);
    check("fw_hash_dout", hash_dout, 32'd0);
    check("fw_err_flags", {30'd0, err_din_ready, err_dout_valid}, 32'd3);
    check("fw_hash_flags", {30'd0, hash_din_ready, hash_dout_valid}, 32'd0);
    check("fw_din_shake", din_shake_enc, 32'h12345678);
    check("fw_keccak_ctl", {30'd0, din_valid_shake_enc, dout_ready_shake_enc}, 32'd3);

    // Done inputs of other phases are ignored in FW.
    enc_done = 1'b1; hash_done = 1'b1;
    step();
    enc_done = 1'b0; hash_done = 1'b0;
    check("fw_other_done", {29'd0, enc_start, hash_start, force_done_shake}, 32'd0);

    err_done = 1'b1;
    #1;
    check("fw_done_pre", {30'd0, done_error, force_done_shake}, 32'd0);
    step();
    err_done = 1'b0;
    check("enc_entry", {29'd0, done_error, force_done_shake, enc_start}, 32'd7);
    check_deselected("enc");
    step();
    check("enc_pulses_end", {29'd0, done_error, force_done_shake, enc_start}, 32'd4);

    err_done = 1'b1; hash_done = 1'b1;
    step();
    err_done = 1'b0; hash_done = 1'b0;
    check("enc_other_done", {29'd0, hash_start, done_encrypt, done}, 32'd0);

    enc_done = 1'b1;
    step();
    enc_done = 1'b0;
    check("hash_entry", {28'd0, done_encrypt, hash_start, force_done_shake, done}, 32'd12);
    check("hash_hash_dout", hash_dout, 32'hDEADBEEF);
    check("hash_err_dout", err_dout, 32'd0);
    check("hash_din_shake", din_shake_enc, 32'hCAFEF00D);
    step();
    check("hash_start_once", {31'd0, hash_start}, 32'd0);

    hash_done = 1'b1;
    #1;
    check("done_pre", {31'd0, done}, 32'd0);
    step();
    hash_done = 1'b0;
    check("done_entry", {30'd0, done, force_done_shake}, 32'd3);
    check_deselected("done");
    for (int c = 0; c < 100; c++) begin
      step();
      check("done_hold", {28'd0, done, done_error, done_encrypt, force_done_shake}, 32'hE);
    end

    // New seed from DONE clears flags; this load stalls mid-way.
    load_words(32'h100, 16, 1'b1);
    finish_load();
    readback();

    err_done = 1'b1;
    step();
    err_done = 1'b0;
    check("enc2_entry", {30'd0, done_error, enc_start}, 32'd3);

    // Asynchronous reset in ENC.
    #2;
    rst = 1'b0;
    #1;
    check("arst_outputs", {25'd0, err_start, enc_start, hash_start, force_done_shake,
                           done_error, done_encrypt, done}, 32'd0);
    check_deselected("arst");
    step();
    step();
    rst = 1'b1;

    load_words(32'h200, 15, 1'b0);
    step();
    seed_valid = 1'b0;
    repeat (3) begin
      check("partial_no_start", {31'd0, err_start}, 32'd0);
      step();
    end
    seed_valid = 1'b1; seed = 32'h20F;
    sb_q.push_back(32'h20F);
    finish_load();
    readback();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
